// File: rtl/friscv_wb_arbiter.sv
// friscv_wb_arbiter
// Shares the single integer register-file write port between NB_UNIT
// processing units. One request is granted per cycle and the grant drives a
// registered write port. A pending-rd bitmask is also exported so the control
// unit can track register hazards.
//
// Build option: define FRISCV_WB_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority, where the lowest valid index always wins
// and no pointer state is kept.
//
// Handshake: a unit raises wb_valid[i] and holds it, together with its
// rd_addr/rd_val/rd_strb payload, until it samples wb_ready[i]=1 on a rising
// edge of aclk. The transfer happens on that edge. wb_ready may depend
// combinationally on wb_valid, but a unit must never make wb_valid depend on
// wb_ready. The register file always accepts, so the output never stalls.

module friscv_wb_arbiter #(
   parameter int XLEN    = 32,
   parameter int NB_UNIT = 3
) (
   input  logic                      aclk,
   input  logic                      srst,
   input  logic [NB_UNIT-1:0]        wb_valid,
   output logic [NB_UNIT-1:0]        wb_ready,
   input  logic [NB_UNIT*5-1:0]      wb_rd_addr,
   input  logic [NB_UNIT*XLEN-1:0]   wb_rd_val,
   input  logic [NB_UNIT*XLEN/8-1:0] wb_rd_strb,
   output logic                      rd_wr,
   output logic [4:0]                rd_addr,
   output logic [XLEN-1:0]           rd_val,
   output logic [XLEN/8-1:0]         rd_strb,
   output logic [31:0]               wb_pending,
   output logic                      wb_busy
);

   localparam int PTR_W  = (NB_UNIT > 2) ? $clog2(NB_UNIT) : 1;
   localparam int STRB_W = XLEN / 8;

   logic                grant_vld;
   logic [PTR_W-1:0]    grant_idx;
   logic [4:0]          grant_addr;
   logic [XLEN-1:0]     grant_val;
   logic [STRB_W-1:0]   grant_strb;

`ifndef FRISCV_WB_FIXED_PRIO_EN
   // Unit that has the highest priority in the current cycle.
   logic [PTR_W-1:0]    rr_ptr;
`endif

   // Pick the first valid unit, starting the search from the priority
   // pointer and wrapping explicitly at NB_UNIT-1 (NB_UNIT need not be 2^n).
   always_comb begin : arbitrate
      logic [PTR_W-1:0] idx;
      grant_vld = 1'b0;
      grant_idx = '0;
`ifdef FRISCV_WB_FIXED_PRIO_EN
      idx = '0;
`else
      idx = rr_ptr;
`endif
      if (!srst) begin
         for (int k = 0; k < NB_UNIT; k++) begin
            if (!grant_vld && wb_valid[idx]) begin
               grant_vld = 1'b1;
               grant_idx = idx;
            end
            idx = (idx == PTR_W'(NB_UNIT - 1)) ? '0 : idx + PTR_W'(1);
         end
      end
   end

   // One-hot ready towards the granted unit and its payload selection.
   always_comb begin : select_payload
      wb_ready   = '0;
      grant_addr = '0;
      grant_val  = '0;
      grant_strb = '0;
      for (int i = 0; i < NB_UNIT; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            wb_ready[i] = grant_vld;
            grant_addr  = wb_rd_addr[5*i +: 5];
            grant_val   = wb_rd_val[XLEN*i +: XLEN];
            grant_strb  = wb_rd_strb[STRB_W*i +: STRB_W];
         end
      end
   end

   // Registered write port. Writes to x0 are accepted but never issued, and
   // the payload registers keep their last value when nothing is granted.
   always_ff @(posedge aclk) begin
      if (srst) begin
         rd_wr   <= 1'b0;
         rd_addr <= '0;
         rd_val  <= '0;
         rd_strb <= '0;
`ifndef FRISCV_WB_FIXED_PRIO_EN
         rr_ptr  <= '0;
`endif
      end else if (grant_vld) begin
         rd_wr   <= (grant_addr != 5'd0);
         rd_addr <= grant_addr;
         rd_val  <= grant_val;
         rd_strb <= grant_strb;
`ifndef FRISCV_WB_FIXED_PRIO_EN
         rr_ptr  <= (grant_idx == PTR_W'(NB_UNIT - 1)) ? '0 : grant_idx + PTR_W'(1);
`endif
      end else begin
         rd_wr   <= 1'b0;
      end
   end

   // Hazard mask: every register targeted by a waiting request or by the
   // write currently on the port. x0 is never reported.
   always_comb begin : pending_mask
      wb_pending = '0;
      for (int i = 0; i < NB_UNIT; i++) begin
         if (wb_valid[i]) begin
            wb_pending[wb_rd_addr[5*i +: 5]] = 1'b1;
         end
      end
      if (rd_wr) begin
         wb_pending[rd_addr] = 1'b1;
      end
      wb_pending[0] = 1'b0;
   end

   assign wb_busy = (|wb_valid) | rd_wr;

endmodule

// File: tb/tb_friscv_wb_arbiter.sv
// Bench for friscv_wb_arbiter: randomized unit traffic plus directed cases,
// compared against a queue-based reference model.

module tb_friscv_wb_arbiter;

  localparam int XLEN = 32;
  localparam int N    = 3;
  localparam int SW   = XLEN / 8;

  // clock / reset
  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  // DUT connections
  logic [N-1:0]      v = '0;
  logic [N-1:0]      wb_ready;
  logic [N*5-1:0]    a = '0;
  logic [N*XLEN-1:0] d = '0;
  logic [N*SW-1:0]   s = '0;
  logic              rd_wr;
  logic [4:0]        rd_addr;
  logic [XLEN-1:0]   rd_val;
  logic [SW-1:0]     rd_strb;
  logic [31:0]       wb_pending;
  logic              wb_busy;

  friscv_wb_arbiter #(.XLEN(XLEN), .NB_UNIT(N)) dut (
    .aclk       (clk),
    .srst       (srst),
    .wb_valid   (v),
    .wb_ready   (wb_ready),
    .wb_rd_addr (a),
    .wb_rd_val  (d),
    .wb_rd_strb (s),
    .rd_wr      (rd_wr),
    .rd_addr    (rd_addr),
    .rd_val     (rd_val),
    .rd_strb    (rd_strb),
    .wb_pending (wb_pending),
    .wb_busy    (wb_busy)
  );

  // expected register-port contents for the cycle after a decision
  typedef struct packed {
    logic            chk_pay;
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] val;
    logic [SW-1:0]   strb;
  } wr_t;

  // expected combinational outputs for the current cycle
  typedef struct packed {
    logic [N-1:0] ready;
    logic [31:0]  pend;
    logic         busy;
  } comb_t;

  wr_t   exp_q[$];
  comb_t comb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         m_ptr = 0;
  logic       m_wr = 1'b0;
  logic [4:0] m_addr = '0;
  int         last_grant = -1;

  // ---------------- driver tasks ----------------
  task automatic issue(input int u, input logic [4:0] ad, input logic [XLEN-1:0] dv,
                       input logic [SW-1:0] sv);
    v[u]            = 1'b1;
    a[5*u +: 5]     = ad;
    d[XLEN*u +: XLEN] = dv;
    s[SW*u +: SW]   = sv;
  endtask

  task automatic issue_rand(input int u);
    logic [4:0] ad;
    if ($urandom_range(0, 1) == 1) ad = 5'($urandom_range(5, 8));
    else                           ad = 5'($urandom_range(0, 31));
    issue(u, ad, $urandom, SW'($urandom_range(0, 15)));
  endtask

  // advance one cycle: retire the unit accepted on this edge, then
  // optionally start new requests on idle units
  task automatic tick(input int prob);
    @(posedge clk);
    #1;
    for (int u = 0; u < N; u++) begin
      if (u == last_grant) v[u] = 1'b0;
    end
    for (int u = 0; u < N; u++) begin
      if (!v[u] && $urandom_range(0, 99) < prob) issue_rand(u);
    end
  endtask

  // ---------------- reference model ----------------
  initial begin
    forever begin
      int    g;
      int    u;
      comb_t c;
      wr_t   e;
      logic [4:0] ad;
      @(posedge clk);
      #3;
      g = -1;
      if (!srst) begin
        for (int k = 0; k < N; k++) begin
`ifdef FRISCV_WB_FIXED_PRIO_EN
          u = k;
`else
          u = (m_ptr + k) % N;
`endif
          if (g < 0 && v[u]) g = u;
        end
      end
      c = '0;
      for (int i = 0; i < N; i++) begin
        if (i == g) c.ready[i] = 1'b1;
        if (v[i]) c.pend[a[5*i +: 5]] = 1'b1;
      end
      if (m_wr) c.pend[m_addr] = 1'b1;
      c.pend[0] = 1'b0;
      c.busy = (|v) | m_wr;
      comb_q.push_back(c);

      e = '0;
      if (srst) begin
        e.chk_pay = 1'b1;
        m_wr  = 1'b0;
        m_ptr = 0;
      end else if (g >= 0) begin
        ad = a[5*g +: 5];
        e.chk_pay = (ad != 5'd0);
        e.we      = (ad != 5'd0);
        e.addr    = ad;
        e.val     = d[XLEN*g +: XLEN];
        e.strb    = s[SW*g +: SW];
        m_wr   = (ad != 5'd0);
        m_addr = ad;
        m_ptr  = (g + 1) % N;
      end else begin
        m_wr = 1'b0;
      end
      exp_q.push_back(e);
      last_grant = g;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    comb_t c;
    wr_t   e;
    if (comb_q.size() > 0) begin
      c = comb_q.pop_front();
      check("wb_ready",   64'(wb_ready),   64'(c.ready));
      check("wb_pending", 64'(wb_pending), 64'(c.pend));
      check("wb_busy",    64'(wb_busy),    64'(c.busy));
    end
    // the entry decided in the previous cycle is now on the register port
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("rd_wr", 64'(rd_wr), 64'(e.we));
      if (e.chk_pay) begin
        check("rd_addr", 64'(rd_addr), 64'(e.addr));
        check("rd_val",  64'(rd_val),  64'(e.val));
        check("rd_strb", 64'(rd_strb), 64'(e.strb));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    srst = 1'b1;
    repeat (3) tick(0);
    srst = 1'b0;

    // single request from unit 1
    issue(1, 5'd5, 32'hDEADBEEF, 4'hF);
    repeat (3) tick(0);

    // write to x0 is accepted but dropped
    issue(0, 5'd0, 32'h0000_1234, 4'h3);
    repeat (3) tick(0);

    // two units targeting the same register
    issue(0, 5'd7, 32'hAAAA_0000, 4'h0);
    issue(2, 5'd7, 32'h5555_FFFF, 4'hC);
    repeat (5) tick(0);

    // saturation starting from reset
    srst = 1'b1;
    for (int u = 0; u < N; u++) if (!v[u]) issue_rand(u);
    repeat (2) tick(100);
    srst = 1'b0;
    repeat (20) tick(100);

    // random traffic
    repeat (300) tick(50);
    repeat (6) tick(0);

    // reset while a write is on the port
    issue(0, 5'd9, 32'h0BAD_F00D, 4'h5);
    tick(0);
    srst = 1'b1;
    if (!v[0]) issue(0, 5'd10, 32'h1111_2222, 4'hA);
    if (!v[1]) issue(1, 5'd11, 32'h3333_4444, 4'h6);
    tick(0);
    srst = 1'b0;
    repeat (5) tick(0);

    repeat (2) @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
